alu4_nibble_sequencer: RTL

//   Operand/writeback stage wrapped around the 4-bit ALU. Holds a nibble register file and a flag register.

---
 rtl/alu4_pkg.sv | 28 ++
 rtl/alu4_regfile.sv | 43 ++++
 rtl/alu4_nibble_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu4_pkg.sv
// Shared definitions for the nibble-sliced ALU sequencer.
// Contents: ALU opcode width and opcode constants, flag bit positions inside
// the {V,Z,RC,MC} flag word, and the sequencer FSM state encoding.
package alu4_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] ALU4_OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] ALU4_OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] ALU4_OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] ALU4_OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] ALU4_OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] ALU4_OP_ROL  = 4'h5;
    localparam logic [OP_W-1:0] ALU4_OP_ROR  = 4'h6;
    localparam logic [OP_W-1:0] ALU4_OP_PASS = 4'h7;

    localparam int FLAG_MC = 0;
    localparam int FLAG_RC = 1;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_V  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu4_regfile.sv
// NREGS x 4-bit register file for the nibble sequencer.
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear of every register
//   we, waddr, wdata      single write port (host write or slice writeback, muxed by the parent)
//   a_addr/a_data         combinational operand-A read port
//   b_addr/b_data         combinational operand-B read port
//   rd_addr/rd_data       combinational host read port
module alu4_regfile #(
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] a_addr,
    output logic [3:0]    a_data,
    input  logic [AW-1:0] b_addr,
    output logic [3:0]    b_data,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data
);

    logic [3:0] regs_r [NREGS];

    // Register storage: cleared on reset, one write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 4'h0;
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Reads see pre-edge contents, so a read during writeback returns the old value.
    assign a_data  = regs_r[a_addr];
    assign b_data  = regs_r[b_addr];
    assign rd_data = regs_r[rd_addr];

endmodule

// File: rtl/alu4_nibble_sequencer.sv
// Operand/writeback sequencer around an external 4-bit ALU. Executes one
// command as len+1 nibble slices, chaining math/rotate carries between slices,
// writing each result nibble back, and posting {V,Z,RC,MC} flags at the end.
// Ports:
//   cmd_valid/cmd_ready + cmd_op/dst/srca/srcb/len/dir   command handshake
//   wr_en/wr_addr/wr_data                                host write (IDLE only)
//   rd_addr/rd_data                                      combinational host read
//   alu_op/alu_a/alu_b/alu_mcin/alu_rcin                 drive to the ALU
//   alu_out/alu_mcout/alu_rcout/alu_v                    results from the ALU
//   done                                                 one-cycle completion pulse
//   flags                                                {V,Z,RC,MC}
// Build option: ALU4_SEQ_CARRY_KEEP_EN -- when defined, the first slice takes
// its carries from the flag register so precision chains across commands;
// otherwise the first slice carries-in are zero.
module alu4_nibble_sequencer
    import alu4_pkg::*;
#(
    parameter  int NREGS  = 8,
    parameter  int MAXLEN = 4,
    localparam int AW     = $clog2(NREGS),
    localparam int LW     = $clog2(MAXLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic [AW-1:0]   cmd_dst,
    input  logic [AW-1:0]   cmd_srca,
    input  logic [AW-1:0]   cmd_srcb,
    input  logic [LW-1:0]   cmd_len,
    input  logic            cmd_dir,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [3:0]      wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [3:0]      rd_data,
    output logic [OP_W-1:0] alu_op,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic            alu_mcin,
    output logic            alu_rcin,
    input  logic [3:0]      alu_out,
    input  logic            alu_mcout,
    input  logic            alu_rcout,
    input  logic            alu_v,
    output logic            done,
    output logic [3:0]      flags
);

    localparam logic [LW-1:0] LEN_ONE = LW'(1);

    seq_state_t      state_r, state_s;
    logic [OP_W-1:0] op_r;
    logic [AW-1:0]   dst_r, srca_r, srcb_r;
    logic [LW-1:0]   len_r, idx_r, cnt_r;
    logic            dir_r, mc_r, rc_r, v_r, z_acc_r;
    logic [3:0]      flags_r;
    logic            mc_init_s, rc_init_s;
    logic            rf_we_s;
    logic [AW-1:0]   rf_waddr_s;
    logic [3:0]      rf_wdata_s;
    logic [AW-1:0]   addr_a_s, addr_b_s, addr_d_s;

`ifdef ALU4_SEQ_CARRY_KEEP_EN
    assign mc_init_s = flags_r[FLAG_MC];
    assign rc_init_s = flags_r[FLAG_RC];
`else
    assign mc_init_s = 1'b0;
    assign rc_init_s = 1'b0;
`endif

    // Slice addresses wrap modulo NREGS through the AW-bit adders.
    assign addr_a_s = srca_r + AW'(idx_r);
    assign addr_b_s = srcb_r + AW'(idx_r);
    assign addr_d_s = dst_r  + AW'(idx_r);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: EXEC runs until the slice counter reaches len.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == len_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Write port mux: slice writeback in EXEC, host write only in IDLE.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = wr_addr;
        rf_wdata_s = wr_data;
        if (state_r == ST_EXEC) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = addr_d_s;
            rf_wdata_s = alu_out;
        end else if ((state_r == ST_IDLE) && wr_en) begin
            rf_we_s    = 1'b1;
        end else begin
            rf_we_s    = 1'b0;
        end
    end

    // Command latch, slice index/counter, carry chain, Z accumulation and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 4'h0;
            dst_r   <= '0;
            srca_r  <= '0;
            srcb_r  <= '0;
            len_r   <= '0;
            dir_r   <= 1'b0;
            idx_r   <= '0;
            cnt_r   <= '0;
            mc_r    <= 1'b0;
            rc_r    <= 1'b0;
            v_r     <= 1'b0;
            z_acc_r <= 1'b0;
            flags_r <= 4'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_r    <= cmd_op;
                        dst_r   <= cmd_dst;
                        srca_r  <= cmd_srca;
                        srcb_r  <= cmd_srcb;
                        len_r   <= cmd_len;
                        dir_r   <= cmd_dir;
                        idx_r   <= cmd_dir ? cmd_len : '0;
                        cnt_r   <= '0;
                        // Preloading the chain latches makes slice 1 identical to later slices.
                        mc_r    <= mc_init_s;
                        rc_r    <= rc_init_s;
                        z_acc_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    mc_r    <= alu_mcout;
                    rc_r    <= alu_rcout;
                    v_r     <= alu_v;
                    z_acc_r <= z_acc_r & (alu_out == 4'h0);
                    idx_r   <= dir_r ? (idx_r - LEN_ONE) : (idx_r + LEN_ONE);
                    cnt_r   <= cnt_r + LEN_ONE;
                end
                ST_DONE: begin
                    flags_r[FLAG_V]  <= v_r;
                    flags_r[FLAG_Z]  <= z_acc_r;
                    flags_r[FLAG_RC] <= rc_r;
                    flags_r[FLAG_MC] <= mc_r;
                end
                default: begin
                    flags_r <= flags_r;
                end
            endcase
        end
    end

    alu4_regfile #(.NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (rf_wdata_s),
        .a_addr  (addr_a_s),
        .a_data  (alu_a),
        .b_addr  (addr_b_s),
        .b_data  (alu_b),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign cmd_ready = (state_r == ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign flags     = flags_r;
    assign alu_op    = op_r;
    assign alu_mcin  = mc_r;
    assign alu_rcin  = rc_r;

endmodule
